serial_feeder: RTL and testbench
================================

# serial_feeder

Upstream companion to the 8-bit LSB-first serializer: owns the 5-bit frame counter `scnt` (period 20) and a small byte FIFO. It accepts bytes from a valid/ready producer and presents them, one per frame, on the serializer's `data_i`/`En` inputs so that the serializer samples them at `scnt == 3`. It also reports frame completion and FIFO status back to the producer side.

## Interface
- `DEPTH`, 8, FIFO depth in bytes; power of two, 2..256.
- `sys_clk` in 1, system clock; all logic on rising edge.
- `rst` in 1, asynchronous active-high reset.
- `wr_data` in 8, byte to enqueue.
- `wr_valid` in 1, producer offers `wr_data`.
- `wr_ready` out 1, FIFO not full; a write is accepted on an edge with `wr_valid & wr_ready`.
- `scnt` out 5, frame counter to the serializer; 0..19, wraps.
- `data_o` out 8, FIFO head to serializer `data_i`; 0x00 when empty.
- `en_n` out 1, to serializer `En`, active low; low iff FIFO non-empty.
- `busy` out 1, high while a popped byte is being shifted out (scnt 4..19 of that frame).
- `frame_done` out 1, one-cycle pulse at the edge where a busy frame ends (`scnt` 19→0).
- `level` out $clog2(DEPTH)+1, current FIFO occupancy.
- `ovf_cnt` out 8, dropped-write counter (see Configuration).

## Operation
- `scnt` increments every cycle; 19 → 0 wrap. Free-running, never stalls.
- FIFO: `DEPTH` × 8 register array, `wr_ptr`/`rd_ptr` of width $clog2(DEPTH); `level` tracks occupancy; full = `level == DEPTH`, empty = `level == 0`.
- Pop: on the edge where `scnt == 3` and FIFO non-empty, `rd_ptr` advances and `level` decrements. This is the same edge at which the serializer loads `data_o` and samples `en_n`.
- `data_o` = `mem[rd_ptr]` combinationally when non-empty, else 0x00. `en_n` = empty, combinational from `level`.
- `busy` set on the pop edge; cleared on the 19→0 edge. `frame_done` asserted during the cycle after that edge (i.e. registered, high while `scnt == 0` following a busy frame).
- Simultaneous write and pop: both take effect; `level` unchanged.
- Write while full: not accepted (`wr_ready` low), even if a pop occurs on the same edge; `wr_ready` derives from pre-edge `level`.
- Write into an empty FIFO on the `scnt == 3` edge: no pop on that edge (`en_n` was high); byte goes out in the next frame.
- Back-to-back frames: with the FIFO non-empty, one byte every 20 cycles, no gap beyond the serializer's cs-high cycles.

## Timing
- Reset values: `scnt` = 0, `level` = 0, pointers = 0, `wr_ready` = 1, `en_n` = 1, `data_o` = 0x00, `busy` = 0, `frame_done` = 0, `ovf_cnt` = 0.
- Reset mid-frame: all state cleared immediately; the queued bytes are lost. `scnt` restarts at 0, so the serializer samples `en_n` = 1 at the next `scnt == 3` and releases cs.
- Latency from write accept to serializer load: the next `scnt == 3` edge strictly after the accept edge when the FIFO was empty. Worst case is 20 cycles; the serial bits appear on the following cycles.
- Serial line occupancy per byte: bit0 valid `scnt` 4–5, bit k valid `scnt` 4+2k..5+2k; cs high again after `scnt == 19`.

## Configuration
- `SERIAL_FEEDER_OVF_EN` defined: `ovf_cnt` increments on each edge with `wr_valid & ~wr_ready`. It saturates at 255 and is cleared only by `rst`.
- Undefined: counter logic omitted; `ovf_cnt` tied to 0x00.

## Test plan
- Reset then idle 40 cycles -> `scnt` cycles 0..19 twice, `en_n` = 1, `data_o` = 0x00, `busy` = 0, `wr_ready` = 1.
- Write 0xA5 at `scnt == 7` -> `en_n` falls next cycle; pop at next `scnt == 3`. `busy` high `scnt` 4..19, `frame_done` pulses at `scnt == 0`, serial model receives 0xA5 LSB first.
- Write 0x01,0x02,0x03 back-to-back -> three consecutive frames 20 cycles apart carry 0x01,0x02,0x03; `level` 3→2→1→0 at successive `scnt == 3` edges.
- Fill DEPTH=8 plus 3 extra writes with `wr_valid` held -> `wr_ready` low at `level` 8. With the macro, `ovf_cnt` = 3; without it, `ovf_cnt` = 0. Exactly 8 bytes transmitted in order.
- Full FIFO, write offered on a `scnt == 3` pop edge -> write rejected, `level` 8→7. The next write is accepted and `level` returns to 8.
- Assert `rst` at `scnt == 10` of a busy frame with `level` 4 -> outputs at reset values immediately; no further bytes popped; serializer cs high by its next `scnt == 19`.

Source files
------------

// File: rtl/serial_feeder.sv
// Frame counter plus byte FIFO feeding an 8-bit LSB-first serializer, one byte per 20-cycle frame.
// Define SERIAL_FEEDER_OVF_EN to build the saturating dropped-write counter behind ovf_cnt.
module serial_feeder #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [4:0]             scnt,
    output logic [7:0]             data_o,
    output logic                   en_n,
    output logic                   busy,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             ovf_cnt
);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned LvlW    = PtrW + 1;
    localparam logic [4:0]  LoadCnt = 5'd3;
    localparam logic [4:0]  LastCnt = 5'd19;

    logic [4:0]      scnt_q, scnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      mem_q [DEPTH];

    logic empty;
    logic wr_fire;
    logic pop;

    assign empty    = (level_q == '0);
    assign wr_ready = (level_q != LvlW'(DEPTH));
    assign wr_fire  = wr_valid & wr_ready;
    // The serializer loads data_o and samples en_n on this same edge.
    assign pop      = (scnt_q == LoadCnt) & ~empty;

    always_comb begin
        scnt_d       = (scnt_q == LastCnt) ? 5'd0 : scnt_q + 5'd1;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        busy_d       = busy_q;
        frame_done_d = busy_q & (scnt_q == LastCnt);

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({wr_fire, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        if (pop) begin
            busy_d = 1'b1;
        end else if (scnt_q == LastCnt) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            scnt_q       <= 5'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            scnt_q       <= scnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: contents are only visible while level is non-zero.
    always_ff @(posedge sys_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign scnt       = scnt_q;
    assign level      = level_q;
    assign en_n       = empty;
    assign data_o     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

`ifdef SERIAL_FEEDER_OVF_EN
    logic [7:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_valid && !wr_ready && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 8'h00;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_feeder.sv
// Self-checking bench for serial_feeder: directed vector table, corner sequences, and random
// traffic checked every cycle against a queue-based reference model.
module tb_serial_feeder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef SERIAL_FEEDER_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [4:0]    scnt;
    logic [7:0]    data_o;
    logic          en_n;
    logic          busy;
    logic          frame_done;
    logic [LW-1:0] level;
    logic [7:0]    ovf_cnt;

    serial_feeder #(.DEPTH(DEPTH)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .scnt       (scnt),
        .data_o     (data_o),
        .en_n       (en_n),
        .busy       (busy),
        .frame_done (frame_done),
        .level      (level),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time position in the frame plus a plain byte queue.
    int           m_scnt;
    byte unsigned m_q[$];
    bit           m_busy;
    bit           m_fd;
    int           m_ovf;
    byte unsigned exp_tx[$];  // bytes the model accepted, in order
    byte unsigned rx[$];      // bytes the serializer loaded

    typedef struct {
        bit         v;
        logic [7:0] d;
        int         n;
        int         scnt;
        int         level;
        bit         en_n;
        logic [7:0] data;
        bit         busy;
        bit         fd;
    } vec_t;

    vec_t tbl[$];

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endfunction

    function automatic void model_reset();
        m_scnt = 0;
        m_q.delete();
        m_busy = 1'b0;
        m_fd   = 1'b0;
        m_ovf  = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d);
        bit rdy;
        bit do_pop;
        rdy    = (m_q.size() < DEPTH);
        do_pop = (m_scnt == 3) && (m_q.size() > 0);
        if (OvfEn && v && !rdy && m_ovf < 255) m_ovf++;
        m_fd = m_busy && (m_scnt == 19);
        if (do_pop) m_busy = 1'b1;
        else if (m_scnt == 19) m_busy = 1'b0;
        if (do_pop) void'(m_q.pop_front());
        if (v && rdy) begin
            m_q.push_back(d);
            exp_tx.push_back(d);
        end
        m_scnt = (m_scnt + 1) % 20;
    endfunction

    function automatic void check_model();
        check("scnt", int'(scnt), m_scnt);
        check("level", int'(level), m_q.size());
        check("data_o", int'(data_o), (m_q.size() > 0) ? int'(m_q[0]) : 0);
        check("en_n", int'(en_n), (m_q.size() == 0) ? 1 : 0);
        check("busy", int'(busy), int'(m_busy));
        check("frame_done", int'(frame_done), int'(m_fd));
        check("wr_ready", int'(wr_ready), (m_q.size() < DEPTH) ? 1 : 0);
        check("ovf_cnt", int'(ovf_cnt), m_ovf);
    endfunction

    function automatic void check_reset_vals(input string tag);
        check({tag, "_scnt"}, int'(scnt), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_en_n"}, int'(en_n), 1);
        check({tag, "_data_o"}, int'(data_o), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_wr_ready"}, int'(wr_ready), 1);
        check({tag, "_ovf_cnt"}, int'(ovf_cnt), 0);
    endfunction

    // Called at a falling edge: drive, advance one clock, compare at the next falling edge.
    task automatic cycle(input bit v, input logic [7:0] d);
        wr_valid = v;
        wr_data  = d;
        if (scnt == 5'd3 && !en_n) rx.push_back(data_o);
        model_step(v, d);
        @(posedge sys_clk);
        @(negedge sys_clk);
        wr_valid = 1'b0;
        check_model();
    endtask

    function automatic void add(input bit v, input logic [7:0] d, input int n, input int s,
                                input int l, input bit e, input logic [7:0] dat, input bit b,
                                input bit f);
        vec_t r;
        r.v = v; r.d = d; r.n = n; r.scnt = s; r.level = l;
        r.en_n = e; r.data = dat; r.busy = b; r.fd = f;
        tbl.push_back(r);
    endfunction

    task automatic check_rx(input string tag, input byte unsigned want[$]);
        check({tag, "_count"}, rx.size(), want.size());
        for (int i = 0; i < want.size() && i < rx.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), int'(rx[i]), int'(want[i]));
        end
    endtask

    initial begin
        byte unsigned want[$];
        int           rx_before;

        // Table: inputs held for n cycles, then expected state (from scnt 0, empty FIFO).
        add(0, 8'h00,  7,  7, 0, 1, 8'h00, 0, 0);
        add(1, 8'hA5,  1,  8, 1, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 15,  3, 1, 0, 8'hA5, 0, 0);
        add(0, 8'h00,  1,  4, 0, 1, 8'h00, 1, 0);
        add(0, 8'h00, 15, 19, 0, 1, 8'h00, 1, 0);
        add(0, 8'h00,  1,  0, 0, 1, 8'h00, 0, 1);
        add(0, 8'h00,  1,  1, 0, 1, 8'h00, 0, 0);
        add(1, 8'h01,  1,  2, 1, 0, 8'h01, 0, 0);
        add(1, 8'h02,  1,  3, 2, 0, 8'h01, 0, 0);
        add(1, 8'h03,  1,  4, 2, 0, 8'h02, 1, 0);
        add(0, 8'h00, 19,  3, 2, 0, 8'h02, 0, 0);
        add(0, 8'h00,  1,  4, 1, 0, 8'h03, 1, 0);
        add(0, 8'h00, 20,  4, 0, 1, 8'h00, 1, 0);
        add(0, 8'h00, 16,  0, 0, 1, 8'h00, 0, 1);
        add(0, 8'h00,  3,  3, 0, 1, 8'h00, 0, 0);
        add(1, 8'h77,  1,  4, 1, 0, 8'h77, 0, 0);
        add(0, 8'h00, 19,  3, 1, 0, 8'h77, 0, 0);
        add(0, 8'h00,  1,  4, 0, 1, 8'h00, 1, 0);

        // Reset is observed before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_vals("reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        check_model();

        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].v, tbl[i].d);
            check($sformatf("vec%0d_scnt", i), int'(scnt), tbl[i].scnt);
            check($sformatf("vec%0d_level", i), int'(level), tbl[i].level);
            check($sformatf("vec%0d_en_n", i), int'(en_n), int'(tbl[i].en_n));
            check($sformatf("vec%0d_data_o", i), int'(data_o), int'(tbl[i].data));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("vec%0d_frame_done", i), int'(frame_done), int'(tbl[i].fd));
        end
        want = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h77};
        check_rx("table_rx", want);

        // Fill past full with wr_valid held, then offer a write on a full pop edge.
        rx.delete();
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 8'(8'hF0 + i));
        check("fill_level", int'(level), DEPTH);
        check("fill_wr_ready", int'(wr_ready), 0);
        check("fill_ovf", int'(ovf_cnt), OvfEn ? 3 : 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00);
        check("full_pop_scnt", int'(scnt), 3);
        cycle(1'b1, 8'hEE);
        check("full_pop_level", int'(level), DEPTH - 1);
        check("full_pop_ovf", int'(ovf_cnt), OvfEn ? 4 : 0);
        cycle(1'b1, 8'hEF);
        check("refill_level", int'(level), DEPTH);
        for (int i = 0; i < 20 * DEPTH + 20; i++) cycle(1'b0, 8'h00);
        want = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hEF};
        check_rx("fill_rx", want);

        // Reset in the middle of a busy frame with four bytes still queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i));
        while (scnt != 5'd4) cycle(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00);
        check("pre_rst_scnt", int'(scnt), 10);
        check("pre_rst_level", int'(level), 4);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        check_model();
        rx_before = rx.size();
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);
        check("post_rst_no_pop", rx.size(), rx_before);

        // Random traffic at several offered loads.
        rx.delete();
        exp_tx.delete();
        for (int i = 0; i < 2000; i++) begin
            int p;
            unique case ((i / 500) % 4)
                0:       p = 10;
                1:       p = 40;
                2:       p = 90;
                default: p = 100;
            endcase
            cycle($urandom_range(99) < p, 8'($urandom));
        end
        for (int i = 0; i < 20 * DEPTH + 40; i++) cycle(1'b0, 8'h00);
        check_rx("random_rx", exp_tx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
